// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per clock, WIDTH+2 cycles per operation.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, ss;
  logic [CW-1:0] cnt;
  logic c, fs, fc, last;
  always_comb begin
    fs = sa[0] ^ sb[0] ^ c;
    fc = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      ss <= '0;
      cnt <= '0;
      c <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          sa <= a;
          sb <= b;
          c <= cin;
          cnt <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          ss <= {fs, ss[WIDTH-1:1]};
          c <= fc;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            sum <= {fs, ss[WIDTH-1:1]};
            cout <= fc;
`ifdef SERIAL_ADDER_OVF_EN
            // c still holds the carry into the MSB on this edge
            ovf <= c ^ fc;
`endif
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder (WIDTH=8).
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n, start, cin;
  logic [7:0] a, b, sum;
  logic busy, done, cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  int tests = 0;
  int fails = 0;
  logic [7:0] hold_sum;
  logic hold_cout;
  int ndone, first, prev;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    for (int i = 0; i < 8; i++) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("sum_hold", sum, hold_sum);
      check("cout_hold", cout, hold_cout);
      tick();
    end
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", sum, es);
    check("cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, eo);
`else
    if (eo === 1'bx) check("ovf_arg", eo, 0);
`endif
    tick();
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    hold_sum = es;
    hold_cout = ec;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    hold_sum = '0; hold_cout = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_no_start", busy, 0);

    do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    do_add(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);
    do_add(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add(8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0);

    // start pulse and operand changes during RUN must be ignored
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        ndone++;
        check("restart_sum", sum, 8'h46);
        check("restart_cout", cout, 0);
      end
      tick();
    end
    check("restart_done_count", ndone, 1);

    // reset mid-RUN aborts with no done pulse
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    a = 8'h01; b = 8'h02; start = 1'b1;
    tick(); tick();
    check("rst_ignores_start", busy, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_sum = '0; hold_cout = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    do_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // start held high: one result every 10 cycles
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    ndone = 0; first = -1; prev = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        ndone++;
        check("b2b_sum", sum, 8'h30);
        if (first < 0) first = i;
        else check("b2b_period", i - prev, 10);
        prev = i;
      end
    end
    check("b2b_count", ndone, 4);
    check("b2b_first", first, 8);
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
